// File: rtl/multi_mode_ring_counter.sv
// -----------------------------------------------------------------------------
// multi_mode_ring_counter
//
// Purpose:
//   Ring (one-hot rotate) or Johnson (twisted ring) counter. It can rotate in
//   either direction. It keeps a phase index that counts steps modulo the
//   period of the current mode, and it gives a one-cycle wrap pulse when that
//   index rolls over. Illegal codes (for example from a parallel load) are
//   flagged. The counter recovers from them on the next enabled cycle.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   reset_i        synchronous active-high reset
//   enable_i       advance one step per cycle when high
//   mode_i         0 = ring, 1 = Johnson
//   dir_i          1 = rotate toward MSB, 0 = rotate toward LSB
//   load_i         load load_value_i into the count
//   load_value_i   value used by a load (not checked)
//   count_o        registered counter state
//   phase_o        registered step index since last restart, modulo period
//   wrap_o         registered one-cycle pulse on phase wrap
//   illegal_o      combinational; count_o is not a legal code for the mode
// -----------------------------------------------------------------------------
module multi_mode_ring_counter #(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  localparam int unsigned      PW    = $clog2(2*WIDTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic [PW-1:0]    phase_o,
  output logic             wrap_o,
  output logic             illegal_o
);

  // Reject parameter values that cannot give a working counter.
  if (WIDTH < 2) begin : g_bad_width
    $error("multi_mode_ring_counter: WIDTH must be >= 2");
  end
  if (!$onehot(SEED)) begin : g_bad_seed
    $error("multi_mode_ring_counter: SEED must be one-hot");
  end

  localparam logic [PW-1:0] PHASE_ZERO     = {PW{1'b0}};
  localparam logic [PW-1:0] PHASE_ONE      = PW'(1);
  localparam logic [PW-1:0] RING_LAST      = PW'(WIDTH - 1);
  localparam logic [PW-1:0] JOHNSON_LAST   = PW'(2*WIDTH - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q,  wrap_d;
  logic             mode_q;
  logic             illegal_s;
  logic [PW-1:0]    phase_last_s;

  // Start value of a mode: SEED for ring, all-zeros for Johnson.
  function automatic logic [WIDTH-1:0] start_value(input logic mode);
    return mode ? {WIDTH{1'b0}} : SEED;
  endfunction

  // A Johnson code has at most one boundary between adjacent bits.
  function automatic logic johnson_legal(input logic [WIDTH-1:0] c);
    logic [WIDTH-2:0] edges;
    edges = c[WIDTH-2:0] ^ c[WIDTH-1:1];
    return ($countones(edges) <= 1);
  endfunction

  // Ring codes are one-hot.
  function automatic logic ring_legal(input logic [WIDTH-1:0] c);
    return $onehot(c);
  endfunction

  // Legality is judged against mode_q, the mode that the count is running in.
  // During a mode-change cycle the restart has priority anyway.
  assign illegal_s = mode_q ? !johnson_legal(count_q) : !ring_legal(count_q);
  assign illegal_o = illegal_s;

  assign phase_last_s = mode_q ? JOHNSON_LAST : RING_LAST;

  // Next-state selection in priority order: load, mode change, recovery, step, hold.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = load_value_i;
      phase_d = PHASE_ZERO;
    end else if (mode_i != mode_q) begin
      count_d = start_value(mode_i);
      phase_d = PHASE_ZERO;
    end else if (enable_i && illegal_s) begin
      // Recovery replaces the step for this cycle.
      count_d = start_value(mode_q);
      phase_d = PHASE_ZERO;
    end else if (enable_i) begin
      if (dir_i) begin
        count_d = {count_q[WIDTH-2:0], mode_q ^ count_q[WIDTH-1]};
        if (phase_q == phase_last_s) begin
          phase_d = PHASE_ZERO;
          wrap_d  = 1'b1;
        end else begin
          phase_d = phase_q + PHASE_ONE;
        end
      end else begin
        count_d = {mode_q ^ count_q[0], count_q[WIDTH-1:1]};
        if (phase_q == PHASE_ZERO) begin
          phase_d = phase_last_s;
          wrap_d  = 1'b1;
        end else begin
          phase_d = phase_q - PHASE_ONE;
        end
      end
    end else begin
      count_d = count_q;
      phase_d = phase_q;
    end
  end

  // State register with synchronous reset. mode_q follows mode_i every cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= start_value(mode_i);
      phase_q <= PHASE_ZERO;
      wrap_q  <= 1'b0;
      mode_q  <= mode_i;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode_i;
    end
  end

  assign count_o = count_q;
  assign phase_o = phase_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_multi_mode_ring_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_mode_ring_counter
//
// Self-checking bench for multi_mode_ring_counter (WIDTH=4, SEED=4'b0001).
// The reference model keeps its own count, phase and mode. It computes the
// next state with shift/mask arithmetic. It checks Johnson legality against
// a table of the 2*WIDTH Johnson codes. Directed scenarios also compare
// against literal sequences.
// -----------------------------------------------------------------------------
module tb_multi_mode_ring_counter;

  localparam int W  = 4;
  localparam int PW = $clog2(2*W);
  localparam logic [W-1:0] MASK = 4'b1111;

  logic          clk;
  logic          reset, enable, mode, dir, load;
  logic [W-1:0]  load_value;
  logic [W-1:0]  count;
  logic [PW-1:0] phase;
  logic          wrap, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [W-1:0]  m_count;
  logic [PW-1:0] m_phase;
  logic          m_wrap;
  logic          m_mode;
  logic [W-1:0]  jcodes [2*W];

  multi_mode_ring_counter #(.WIDTH(W), .SEED(4'b0001)) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .mode_i(mode),
    .dir_i(dir), .load_i(load), .load_value_i(load_value),
    .count_o(count), .phase_o(phase), .wrap_o(wrap), .illegal_o(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_legal(input logic [W-1:0] c, input logic md);
    logic hit;
    hit = 1'b0;
    if (md) begin
      for (int k = 0; k < 2*W; k++) if (jcodes[k] == c) hit = 1'b1;
    end else begin
      hit = ($countones(c) == 1);
    end
    return hit;
  endfunction

  function automatic logic [W-1:0] m_start(input logic md);
    return md ? 4'b0000 : 4'b0001;
  endfunction

  // Drive one cycle, advance the model at the edge, return 1 ns after it.
  task automatic tick(input logic rs, input logic ld, input logic [W-1:0] lv,
                      input logic md, input logic dr, input logic en);
    int p, ph;
    logic prev_mode;
    reset = rs; load = ld; load_value = lv; mode = md; dir = dr; enable = en;
    @(posedge clk);
    if (rs) begin
      m_count = m_start(md); m_phase = '0; m_wrap = 1'b0; m_mode = md;
    end else begin
      prev_mode = m_mode;
      m_mode    = md;
      m_wrap    = 1'b0;
      if (ld) begin
        m_count = lv; m_phase = '0;
      end else if (md != prev_mode) begin
        m_count = m_start(md); m_phase = '0;
      end else if (en && !m_legal(m_count, prev_mode)) begin
        m_count = m_start(md); m_phase = '0;
      end else if (en) begin
        p  = md ? 2*W : W;
        ph = int'(m_phase);
        if (dr) begin
          if (md) m_count = ((m_count << 1) & MASK) | {3'b000, ~m_count[W-1]};
          else    m_count = ((m_count << 1) & MASK) | (m_count >> (W-1));
          ph = (ph + 1) % p;
          m_wrap = (ph == 0);
        end else begin
          if (md) m_count = (m_count >> 1) | {~m_count[0], 3'b000};
          else    m_count = (m_count >> 1) | {m_count[0], 3'b000};
          ph = (ph + p - 1) % p;
          m_wrap = (ph == p - 1);
        end
        m_phase = PW'(ph);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({count, phase, wrap, illegal} !== {4'b0001, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ring: got count=%b phase=%0d wrap=%b illegal=%b want 0001/0/0/0",
               count, phase, wrap, illegal);
    end
  endtask

  task automatic test_ring_up();
    logic [W-1:0] exp_c [4];
    logic [2:0]   exp_p [4];
    exp_c = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_p = '{3'd1, 3'd2, 3'd3, 3'd0};
    tick(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if ({count, phase, wrap, illegal} !== {exp_c[i], exp_p[i], (i == 3), 1'b0}) begin
        n_fail++;
        $display("FAIL ring_up[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/0",
                 i, count, phase, wrap, illegal, exp_c[i], exp_p[i], (i == 3));
      end
    end
  endtask

  task automatic test_johnson_up();
    logic [W-1:0] exp_c [8];
    exp_c = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    tick(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({count, phase, illegal} !== {4'b0000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL johnson_reset: got %b/%0d/%b want 0000/0/0", count, phase, illegal);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if ({count, phase, wrap, illegal} !== {exp_c[i], 3'((i + 1) % 8), (i == 7), 1'b0}) begin
        n_fail++;
        $display("FAIL johnson_up[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/0",
                 i, count, phase, wrap, illegal, exp_c[i], (i + 1) % 8, (i == 7));
      end
    end
  endtask

  task automatic test_ring_down();
    tick(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({count, phase, wrap} !== {4'b1000, 3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL ring_down_wrap: got %b/%0d/%b want 1000/3/1", count, phase, wrap);
    end
    tick(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({count, phase, wrap} !== {4'b0100, 3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL ring_down_next: got %b/%0d/%b want 0100/2/0", count, phase, wrap);
    end
  endtask

  task automatic test_load_illegal();
    tick(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({count, phase, illegal} !== {4'b0110, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL load_illegal: got %b/%0d/%b want 0110/0/1", count, phase, illegal);
    end
    tick(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({count, illegal} !== {4'b0110, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_hold: got %b/%b want 0110/1", count, illegal);
    end
    tick(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({count, phase, wrap, illegal} !== {4'b0001, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_recover: got %b/%0d/%b/%b want 0001/0/0/0",
               count, phase, wrap, illegal);
    end
  endtask

  task automatic test_mode_change();
    tick(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({count, phase, wrap} !== {4'b0000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mode_change: got %b/%0d/%b want 0000/0/0", count, phase, wrap);
    end
    // The load wins over a mode change in the same cycle.
    tick(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 4'b1010, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({count, phase, illegal} !== {4'b1010, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mode_vs_load: got %b/%0d/%b want 1010/0/1", count, phase, illegal);
    end
  endtask

  task automatic test_reset_priority();
    tick(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (count !== 4'b0111) begin
      n_fail++;
      $display("FAIL johnson_pre_reset: got %b want 0111", count);
    end
    tick(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({count, phase, wrap} !== {4'b0000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_over_load: got %b/%0d/%b want 0000/0/0", count, phase, wrap);
    end
    tick(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({count, phase} !== {4'b0001, 3'd1}) begin
      n_fail++;
      $display("FAIL resume_after_reset: got %b/%0d want 0001/1", count, phase);
    end
  endtask

  task automatic test_random();
    logic md;
    md = 1'b0;
    tick(1'b1, 1'b0, 4'b0000, md, 1'b1, 1'b1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(24) == 0) md = ~md;
      tick(($urandom_range(49) == 0), ($urandom_range(11) == 0), 4'($urandom),
           md, 1'($urandom), ($urandom_range(3) != 0));
      n_checks++;
      if ({count, phase, wrap, illegal} !==
          {m_count, m_phase, m_wrap, !m_legal(m_count, m_mode)}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i,
                 count, phase, wrap, illegal, m_count, m_phase, m_wrap,
                 !m_legal(m_count, m_mode));
      end
    end
  endtask

  initial begin
    // Johnson codes: k ones filling from the LSB, then zeros filling from the LSB.
    for (int k = 0; k < W; k++) begin
      jcodes[k]     = 4'((1 << k) - 1);
      jcodes[k + W] = MASK & ~4'((1 << k) - 1);
    end
    reset = 1'b1; enable = 1'b0; mode = 1'b0; dir = 1'b1; load = 1'b0;
    load_value = 4'b0000;
    test_reset();
    test_ring_up();
    test_johnson_up();
    test_ring_down();
    test_load_illegal();
    test_mode_change();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
